uart_fifo_top: RTL
==================

UART_FIFO_TOP -- requirements
Module: uart_fifo_top

Interface
REQ-001 The block SHALL have parameter CLK_RATE, default 27000000, meaning clock frequency in Hz.
REQ-002 The block SHALL have parameter BPS_RATE, default 115200, meaning baud rate.
REQ-003 The block SHALL have parameter DATA_W, default 8, meaning data bits per frame (legal 5..9).
REQ-004 The block SHALL have parameter PARITY_MODE, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning 1 or 2 stop bits transmitted.
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 16, meaning words per FIFO (power of 2, >=2).
REQ-007 The block SHALL have port clk, input, 1, the single clock.
REQ-008 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 The block SHALL have port rxd, input, 1, asynchronous serial in.
REQ-010 The block SHALL have port txd, output, 1, serial out, idle high.
REQ-011 The block SHALL have port tx_data, input, DATA_W, the word to send.
REQ-012 The block SHALL have port tx_valid, input, 1, and port tx_ready, output, 1: TX FIFO push handshake.
REQ-013 The block SHALL have port rx_data, output, DATA_W, and port rx_valid, output, 1: RX FIFO head.
REQ-014 The block SHALL have port rx_ready, input, 1, the RX pop request.
REQ-015 The block SHALL have ports rx_parity_err and rx_frame_err, output, 1 each: error flags of the head word.
REQ-016 The block SHALL have port rx_overflow, output, 1, a one-cycle pulse on a dropped RX word.
REQ-017 The block SHALL have ports tx_count and rx_count, output, $clog2(FIFO_DEPTH)+1 each: FIFO occupancy.

Function
REQ-018 Bit period SHALL be BIT_CNT = CLK_RATE/BPS_RATE clock cycles, integer-truncated.
REQ-019 TX push SHALL occur on tx_valid && tx_ready; tx_ready = TX FIFO not full.
REQ-020 TX FSM SHALL use states IDLE->START->DATA->PARITY (skipped if PARITY_MODE=0)->STOP->IDLE, each bit lasting BIT_CNT cycles, data sent LSB first.
REQ-021 In IDLE with TX FIFO non-empty, TX SHALL pop one word; txd SHALL fall 2 cycles after the handshake cycle when TX is idle and the FIFO is empty.
REQ-022 STOP SHALL last STOP_BITS*BIT_CNT cycles; a queued word SHALL start on the cycle after STOP ends, with no extra idle.
REQ-023 rxd SHALL pass through a 2-flop synchroniser; RX IDLE SHALL detect a synchronised falling edge.
REQ-024 RX SHALL re-sample the start bit at BIT_CNT/2; if high, it SHALL return to IDLE (glitch reject) with no push.
REQ-025 RX SHALL sample each data, parity and first stop bit at mid-bit; parity_err = mismatch per PARITY_MODE (always 0 when none); frame_err = stop sample 0.
REQ-026 At the stop-bit mid sample RX SHALL push {frame_err, parity_err, data} and return to IDLE; a second stop bit is not checked.
REQ-027 If the RX FIFO is full at push, the word SHALL be dropped and rx_overflow SHALL pulse high one cycle; FIFO contents unchanged.
REQ-028 The RX FIFO SHALL be first-word-fall-through: rx_valid = not empty, and rx_data/flags SHALL show the head; pop SHALL occur on rx_valid && rx_ready.
REQ-029 Simultaneous push and pop SHALL keep the count unchanged, including on a full RX FIFO (the pop frees the slot, so no overflow).
REQ-030 Counts SHALL wrap-free saturate at 0..FIFO_DEPTH; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 On rst all of the following SHALL hold on the next edge: txd=1, tx_ready=1, rx_valid=0, flags=0, rx_overflow=0, counts=0, both FSMs IDLE, FIFOs empty.
REQ-032 Reset mid-frame SHALL abort the frame, force txd=1 next cycle, and discard any partial RX word.

Configuration
REQ-033 When macro UART_LOOPBACK_EN is defined, the block SHALL add input port loopback; loopback=1 routes the internal TX serial stream to the RX synchroniser input and holds txd=1.
REQ-034 Without UART_LOOPBACK_EN, port loopback SHALL not exist and RX SHALL always take rxd.

Verification (CLK_RATE=1843200, BPS_RATE=115200, BIT_CNT=16)
REQ-035 Push 0xA5, 8N1 -> txd low at handshake+2 cycles, then bits 1,0,1,0,0,1,0,1, stop 1, each 16 cycles, frame length 160 cycles.
REQ-036 Drive rxd 0x3C with even parity bit 0 -> rx_valid=1, rx_data=0x3C, both errors 0; repeat with parity bit 1 -> rx_parity_err=1.
REQ-037 Drive a frame with stop bit 0 -> word pushed with rx_frame_err=1.
REQ-038 FIFO_DEPTH=4, receive 5 frames with rx_ready=0 -> rx_count=4, exactly one rx_overflow pulse, reads return first 4 words in order.
REQ-039 rxd low pulse of 4 cycles -> no push, rx_count stays 0.
REQ-040 Assert rst at cycle 80 of a TX frame -> txd=1 next cycle, tx_count=0, no further frame output.

Source files
------------

// File: rtl/uart_fifo_top.sv
// uart_fifo_top: UART transmitter and receiver, each buffered by a FIFO.
// TX words are queued through a valid/ready push port and serialised LSB first.
// RX frames are stored with their error flags in a first-word-fall-through FIFO.
// Optional feature macro: UART_LOOPBACK_EN adds a 'loopback' input. When it is
// high, the TX stream feeds the RX synchroniser and txd is held idle high.
module uart_fifo_top #(
  parameter int CLK_RATE    = 27000000,
  parameter int BPS_RATE    = 115200,
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef UART_LOOPBACK_EN
  input  logic                          loopback,
`endif
  input  logic                          rxd,
  output logic                          txd,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count
);

  localparam int BIT_CNT = CLK_RATE / BPS_RATE;
  localparam int CNT_W   = $clog2(STOP_BITS * BIT_CNT + 1);
  localparam int IDX_W   = $clog2(DATA_W);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CW      = PTR_W + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * BIT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [CW-1:0]    FULL_C    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]    CNT_INC   = CW'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [CW-1:0]     tx_count_reg;
  logic              tx_push, tx_pop;
  logic [DATA_W-1:0] tx_head;

  assign tx_ready = (tx_count_reg != FULL_C);
  assign tx_push  = tx_valid && tx_ready;
  assign tx_head  = tx_mem[tx_rd_ptr_reg];
  assign tx_count = tx_count_reg;

  // TX storage write port
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= tx_data;
  end

  // TX pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_ONE;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_count_reg <= tx_count_reg + CNT_INC;
        2'b01:   tx_count_reg <= tx_count_reg - CNT_INC;
        default: tx_count_reg <= tx_count_reg;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  logic [2:0]        tx_state_reg;
  logic [CNT_W-1:0]  tx_timer_reg;
  logic [IDX_W-1:0]  tx_idx_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic              tx_par_reg;
  logic              txd_reg;

  // A word is taken when idle, or on the last stop cycle so frames run back to back
  assign tx_pop = (tx_count_reg != '0) &&
                  ((tx_state_reg == S_IDLE) ||
                   ((tx_state_reg == S_STOP) && (tx_timer_reg == '0)));

  // Serialise start, data (LSB first), optional parity and stop bits
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= S_IDLE;
      tx_timer_reg <= '0;
      tx_idx_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      txd_reg      <= 1'b1;
    end else if (tx_pop) begin
      tx_state_reg <= S_START;
      tx_timer_reg <= BIT_LAST;
      tx_shift_reg <= tx_head;
      tx_par_reg   <= (PARITY_MODE == 1) ? ~(^tx_head) : (^tx_head);
      txd_reg      <= 1'b0;
    end else begin
      case (tx_state_reg)
        S_IDLE: txd_reg <= 1'b1;
        S_START: begin
          if (tx_timer_reg == '0) begin
            tx_state_reg <= S_DATA;
            tx_timer_reg <= BIT_LAST;
            tx_idx_reg   <= '0;
            txd_reg      <= tx_shift_reg[0];
            tx_shift_reg <= tx_shift_reg >> 1;
          end else tx_timer_reg <= tx_timer_reg - CNT_ONE;
        end
        S_DATA: begin
          if (tx_timer_reg == '0) begin
            tx_timer_reg <= BIT_LAST;
            if (tx_idx_reg == IDX_LAST) begin
              if (PARITY_MODE != 0) begin
                tx_state_reg <= S_PARITY;
                txd_reg      <= tx_par_reg;
              end else begin
                tx_state_reg <= S_STOP;
                tx_timer_reg <= STOP_LAST;
                txd_reg      <= 1'b1;
              end
            end else begin
              tx_idx_reg   <= tx_idx_reg + IDX_ONE;
              txd_reg      <= tx_shift_reg[0];
              tx_shift_reg <= tx_shift_reg >> 1;
            end
          end else tx_timer_reg <= tx_timer_reg - CNT_ONE;
        end
        S_PARITY: begin
          if (tx_timer_reg == '0) begin
            tx_state_reg <= S_STOP;
            tx_timer_reg <= STOP_LAST;
            txd_reg      <= 1'b1;
          end else tx_timer_reg <= tx_timer_reg - CNT_ONE;
        end
        S_STOP: begin
          if (tx_timer_reg == '0) tx_state_reg <= S_IDLE;
          else tx_timer_reg <= tx_timer_reg - CNT_ONE;
          txd_reg <= 1'b1;
        end
        default: begin
          tx_state_reg <= S_IDLE;
          txd_reg      <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- Serial routing ----------------
  logic rx_src;
`ifdef UART_LOOPBACK_EN
  assign txd    = loopback ? 1'b1 : txd_reg;
  assign rx_src = loopback ? txd_reg : rxd;
`else
  assign txd    = txd_reg;
  assign rx_src = rxd;
`endif

  // ---------------- RX synchroniser ----------------
  logic rx_s1_reg, rx_s2_reg, rx_prev_reg;
  logic rx_fall;

  // Two flops for metastability, a third to spot the falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_reg   <= 1'b1;
      rx_s2_reg   <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_s1_reg   <= rx_src;
      rx_s2_reg   <= rx_s1_reg;
      rx_prev_reg <= rx_s2_reg;
    end
  end

  assign rx_fall = rx_prev_reg && !rx_s2_reg;

  // ---------------- RX FSM ----------------
  logic [2:0]        rx_state_reg;
  logic [CNT_W-1:0]  rx_timer_reg;
  logic [IDX_W-1:0]  rx_idx_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic              rx_perr_reg;
  logic              rx_push;
  logic [DATA_W+1:0] rx_word;

  assign rx_push = (rx_state_reg == S_STOP) && (rx_timer_reg == '0);
  assign rx_word = {~rx_s2_reg, rx_perr_reg, rx_shift_reg};

  // Mid-bit sampling; a start bit that is high again at half period is a glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_reg <= S_IDLE;
      rx_timer_reg <= '0;
      rx_idx_reg   <= '0;
      rx_shift_reg <= '0;
      rx_perr_reg  <= 1'b0;
    end else begin
      case (rx_state_reg)
        S_IDLE: begin
          if (rx_fall) begin
            rx_state_reg <= S_START;
            rx_timer_reg <= HALF_LAST;
            rx_perr_reg  <= 1'b0;
          end
        end
        S_START: begin
          if (rx_timer_reg == '0) begin
            if (rx_s2_reg) rx_state_reg <= S_IDLE;
            else begin
              rx_state_reg <= S_DATA;
              rx_timer_reg <= BIT_LAST;
              rx_idx_reg   <= '0;
            end
          end else rx_timer_reg <= rx_timer_reg - CNT_ONE;
        end
        S_DATA: begin
          if (rx_timer_reg == '0) begin
            rx_shift_reg <= {rx_s2_reg, rx_shift_reg[DATA_W-1:1]};
            rx_timer_reg <= BIT_LAST;
            if (rx_idx_reg == IDX_LAST)
              rx_state_reg <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            else
              rx_idx_reg <= rx_idx_reg + IDX_ONE;
          end else rx_timer_reg <= rx_timer_reg - CNT_ONE;
        end
        S_PARITY: begin
          if (rx_timer_reg == '0) begin
            rx_perr_reg  <= (PARITY_MODE == 1) ? ~((^rx_shift_reg) ^ rx_s2_reg)
                                               :  ((^rx_shift_reg) ^ rx_s2_reg);
            rx_state_reg <= S_STOP;
            rx_timer_reg <= BIT_LAST;
          end else rx_timer_reg <= rx_timer_reg - CNT_ONE;
        end
        S_STOP: begin
          if (rx_timer_reg == '0) rx_state_reg <= S_IDLE;
          else rx_timer_reg <= rx_timer_reg - CNT_ONE;
        end
        default: rx_state_reg <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO (first-word-fall-through) ----------------
  logic [DATA_W+1:0] rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [CW-1:0]     rx_count_reg;
  logic              rx_overflow_reg;
  logic              rx_pop, rx_wr;
  logic [DATA_W+1:0] rx_head;

  assign rx_valid = (rx_count_reg != '0);
  assign rx_pop   = rx_valid && rx_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the word
  assign rx_wr    = rx_push && ((rx_count_reg != FULL_C) || rx_pop);
  assign rx_head  = rx_valid ? rx_mem[rx_rd_ptr_reg] : '0;
  assign {rx_frame_err, rx_parity_err, rx_data} = rx_head;
  assign rx_count    = rx_count_reg;
  assign rx_overflow = rx_overflow_reg;

  // RX storage write port
  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wr_ptr_reg] <= rx_word;
  end

  // RX pointers, occupancy and drop pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr_reg   <= '0;
      rx_rd_ptr_reg   <= '0;
      rx_count_reg    <= '0;
      rx_overflow_reg <= 1'b0;
    end else begin
      rx_overflow_reg <= rx_push && !rx_wr;
      if (rx_wr)  rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_ONE;
      if (rx_pop) rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_ONE;
      case ({rx_wr, rx_pop})
        2'b10:   rx_count_reg <= rx_count_reg + CNT_INC;
        2'b01:   rx_count_reg <= rx_count_reg - CNT_INC;
        default: rx_count_reg <= rx_count_reg;
      endcase
    end
  end

endmodule
